// File: rtl/def_pkg.sv
// def_pkg: shared widths, FSM states and buffer-role helpers for the projection store
package def_pkg;
  localparam int ANGLE_W  = 9;
  localparam int S_W      = 9;
  localparam int DATA_W   = 16;
  localparam int S_COUNT  = 256;
  localparam int FILL_LAT = 2;

  typedef enum logic [2:0] {
    READY,
    FILL,
    FILL_WORK_1,
    FILL_WORK_2,
    WORK_1,
    WORK_2
  } state_t;

  // fill buffer index for a rotate_sel value: 0 -> 0, 1 -> 2, 2 -> 1
  function automatic logic [1:0] fill_idx(input logic [1:0] sel);
    return (sel == 2'd0) ? 2'd0 : (sel == 2'd1) ? 2'd2 : 2'd1;
  endfunction

  // pr0 follows fill and pr1 follows pr0, cyclically over the three buffers
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction
endpackage

// File: rtl/def_buffer.sv
// def_buffer: one projection buffer with host fill sequencer and a registered read port
module def_buffer
  import def_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_kick,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [S_W-1:0]    i_rd_addr,
  output logic [S_W-1:0]    o_fill_addr,
  output logic              o_fill_done,
  output logic [DATA_W-1:0] o_rd_data
);
  localparam int A_W = $clog2(S_COUNT);
  localparam logic [S_W-1:0] LAST = S_W'(S_COUNT - 1);

  logic [DATA_W-1:0]   r_mem [S_COUNT];
  logic                r_active;
  logic [S_W-1:0]      r_cnt;
  logic [FILL_LAT-1:0] r_dly_vld;
  logic [S_W-1:0]      r_dly_addr [FILL_LAT];
  logic                r_done;
  logic [DATA_W-1:0]   r_rd;
  logic                w_wr;
  logic [S_W-1:0]      w_wr_addr;

  assign w_wr        = r_dly_vld[FILL_LAT-1];
  assign w_wr_addr   = r_dly_addr[FILL_LAT-1];
  assign o_fill_addr = r_cnt;
  assign o_fill_done = r_done;
  assign o_rd_data   = r_rd;

  // address walk: a kick restarts it at 0, it stops after issuing the last sample
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
    end else if (i_kick) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
    end else if (r_active) begin
      r_active <= (r_cnt != LAST);
      r_cnt    <= (r_cnt == LAST) ? r_cnt : r_cnt + S_W'(1);
    end
  end

  // valid half of the delay line; cleared on reset so an aborted fill stops writing
  always_ff @(posedge clk) begin
    if (!reset_n) r_dly_vld <= '0;
    else r_dly_vld <= (r_dly_vld << 1) | FILL_LAT'(r_active);
  end

  // address half of the delay line, aligning each address with its returning sample
  always_ff @(posedge clk) begin
    r_dly_addr[0] <= r_cnt;
    for (int i = 1; i < FILL_LAT; i++) r_dly_addr[i] <= r_dly_addr[i-1];
  end

  // fill_done drops on a kick and returns once the last sample has been written
  always_ff @(posedge clk) begin
    if (!reset_n) r_done <= 1'b1;
    else if (i_kick) r_done <= 1'b0;
    else if (w_wr && w_wr_addr == LAST) r_done <= 1'b1;
  end

  // sample RAM: delayed-address write port, one-cycle registered read port
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[w_wr_addr[A_W-1:0]] <= i_wdata;
    r_rd <= r_mem[i_rd_addr[A_W-1:0]];
  end
endmodule

// File: rtl/def.sv
// def: triple-buffered filtered-projection store rotating fill -> pr0 -> pr1 -> fill
module def
  import def_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ANGLE_W-1:0]       hs_angle,
  input  logic                     hs_has_next_angle,
  input  logic                     hs_next_angle_ack,
  input  logic [DATA_W-1:0]        hs_val,
  input  logic [S_W-1:0]           pr0_s_val,
  input  logic [S_W-1:0]           pr1_s_val,
  input  logic                     pr_next_angle,
  input  logic                     pr_done,
  output logic [S_W-1:0]           hs_s_val,
  output logic                     hs_next_angle,
  output logic [ANGLE_W-1:0]       pr0_angle,
  output logic [ANGLE_W-1:0]       pr1_angle,
  output logic                     pr0_angle_valid,
  output logic                     pr1_angle_valid,
  output logic                     pr_next_angle_ack,
  output logic signed [DATA_W-1:0] pr0_val,
  output logic signed [DATA_W-1:0] pr1_val
);
  state_t             r_state, w_state_nxt;
  logic [1:0]         r_sel;
  logic [1:0]         w_fill, w_pr0, w_pr1;
  logic               w_rotate, w_hs_req, w_pr_ack, w_fill_done;
  logic [ANGLE_W-1:0] r_fill_angle, r_pr0_angle, r_pr1_angle;
  logic               r_fill_valid, r_pr0_valid, r_pr1_valid;
  logic [S_W-1:0]     w_addr [3];
  logic [DATA_W-1:0]  w_rd [3];
  logic [2:0]         w_done;

  assign w_fill            = fill_idx(r_sel);
  assign w_pr0             = next_idx(w_fill);
  assign w_pr1             = next_idx(w_pr0);
  assign w_fill_done       = w_done[w_fill];
  assign hs_s_val          = w_addr[w_fill];
  assign hs_next_angle     = w_hs_req;
  assign pr_next_angle_ack = w_pr_ack;
  assign pr0_val           = w_rd[w_pr0];
  assign pr1_val           = w_rd[w_pr1];
  assign pr0_angle         = r_pr0_angle;
  assign pr1_angle         = r_pr1_angle;
  assign pr0_angle_valid   = r_pr0_valid;
  assign pr1_angle_valid   = r_pr1_valid;

  // the buffer leaving the pr1 role is kicked to refill on the rotating edge
  for (genvar b = 0; b < 3; b++) begin : g_buf
    def_buffer u_buf (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_kick      (w_rotate && w_pr1 == 2'(b)),
      .i_wdata     (hs_val),
      .i_rd_addr   (w_pr0 == 2'(b) ? pr0_s_val : w_pr1 == 2'(b) ? pr1_s_val : '0),
      .o_fill_addr (w_addr[b]),
      .o_fill_done (w_done[b]),
      .o_rd_data   (w_rd[b])
    );
  end

  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= READY;
    else r_state <= w_state_nxt;
  end

  // next state: every transition except pr_done is tied to a rotation
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      READY:       w_state_nxt = w_rotate ? FILL : READY;
      FILL:        w_state_nxt = w_rotate ? FILL_WORK_1 : FILL;
      FILL_WORK_1: w_state_nxt = w_rotate ? FILL_WORK_2 : FILL_WORK_1;
      FILL_WORK_2: w_state_nxt = w_rotate ? (hs_has_next_angle ? FILL_WORK_2 : WORK_1) : FILL_WORK_2;
      WORK_1:      w_state_nxt = w_rotate ? WORK_2 : WORK_1;
      WORK_2:      w_state_nxt = pr_done ? READY : WORK_2;
      default:     w_state_nxt = READY;
    endcase
  end

  // handshake outputs and rotate strobe; nothing rotates while the fill buffer is still filling
  always_comb begin
    w_hs_req = 1'b0;
    w_rotate = 1'b0;
    w_pr_ack = 1'b0;
    case (r_state)
      READY: w_rotate = w_fill_done && hs_next_angle_ack;
      FILL: begin
        w_hs_req = w_fill_done;
        w_rotate = w_fill_done && hs_next_angle_ack;
        w_pr_ack = w_fill_done && hs_next_angle_ack;
      end
      FILL_WORK_1, FILL_WORK_2: begin
        w_hs_req = w_fill_done && pr_next_angle && hs_has_next_angle;
        w_rotate = w_fill_done && pr_next_angle && (!hs_has_next_angle || hs_next_angle_ack);
        w_pr_ack = w_fill_done && pr_next_angle && (!hs_has_next_angle || hs_next_angle_ack);
      end
      WORK_1: begin
        w_rotate = w_fill_done && pr_next_angle;
        w_pr_ack = w_fill_done && pr_next_angle;
      end
      default: w_hs_req = 1'b0;
    endcase
  end

  // rotate_sel advances 0 -> 1 -> 2 -> 0 on each rotation
  always_ff @(posedge clk) begin
    if (!reset_n) r_sel <= 2'd0;
    else if (w_rotate) r_sel <= (r_sel == 2'd2) ? 2'd0 : r_sel + 2'd1;
  end

  // angle tags and valids move along with the buffers on each rotation
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fill_angle <= '0;
      r_pr0_angle  <= '0;
      r_pr1_angle  <= '0;
      r_fill_valid <= 1'b0;
      r_pr0_valid  <= 1'b0;
      r_pr1_valid  <= 1'b0;
    end else if (w_rotate) begin
      r_fill_angle <= hs_angle;
      r_pr0_angle  <= r_fill_angle;
      r_pr1_angle  <= r_pr0_angle;
      r_fill_valid <= hs_has_next_angle;
      r_pr0_valid  <= r_fill_valid;
      r_pr1_valid  <= r_pr0_valid;
    end
  end
endmodule

// File: tb/tb_def.sv
// tb_def: scoreboard bench for the triple-buffered projection store
module tb_def;
  import def_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [ANGLE_W-1:0] hs_angle = '0;
  logic hs_has_next_angle = 1'b0;
  logic hs_next_angle_ack = 1'b0;
  logic [DATA_W-1:0] hs_val;
  logic [S_W-1:0] pr0_s_val = '0;
  logic [S_W-1:0] pr1_s_val = '0;
  logic pr_next_angle = 1'b0;
  logic pr_done = 1'b0;
  logic [S_W-1:0] hs_s_val;
  logic hs_next_angle;
  logic [ANGLE_W-1:0] pr0_angle, pr1_angle;
  logic pr0_angle_valid, pr1_angle_valid, pr_next_angle_ack;
  logic signed [DATA_W-1:0] pr0_val, pr1_val;

  typedef struct { int a0; int a1; logic v0; logic v1; } ang_t;
  typedef struct { logic c0; logic c1; int d0; int d1; } rd_t;

  int n_chk = 0;
  int n_fail = 0;
  ang_t ang_q[$];
  rd_t rd_q[$];
  ang_t e_ang;
  rd_t e_rd;
  logic ang_pend = 1'b0;
  logic rd_req = 1'b0;
  logic rd_pend = 1'b0;
  logic [DATA_W-1:0] base = '0;
  logic [S_W-1:0] h1 = '0;
  logic [S_W-1:0] h2 = '0;
  logic hs_at;
  int n, cnt;

  def dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .hs_angle          (hs_angle),
    .hs_has_next_angle (hs_has_next_angle),
    .hs_next_angle_ack (hs_next_angle_ack),
    .hs_val            (hs_val),
    .pr0_s_val         (pr0_s_val),
    .pr1_s_val         (pr1_s_val),
    .pr_next_angle     (pr_next_angle),
    .pr_done           (pr_done),
    .hs_s_val          (hs_s_val),
    .hs_next_angle     (hs_next_angle),
    .pr0_angle         (pr0_angle),
    .pr1_angle         (pr1_angle),
    .pr0_angle_valid   (pr0_angle_valid),
    .pr1_angle_valid   (pr1_angle_valid),
    .pr_next_angle_ack (pr_next_angle_ack),
    .pr0_val           (pr0_val),
    .pr1_val           (pr1_val)
  );

  always #5 clk = ~clk;

  // host RAM: returns base + address, FILL_LAT (=2) cycles after the address
  always @(posedge clk) begin
    h1 <= hs_s_val;
    h2 <= h1;
  end
  assign hs_val = DATA_W'(h2) + base;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue one read on both ports and queue the expected data
  task automatic rd(input int a0, input int e0, input logic c0, input int a1, input int e1, input logic c1);
    pr0_s_val = S_W'(a0);
    pr1_s_val = S_W'(a1);
    rd_q.push_back('{c0, c1, e0, e1});
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  // bounded wait for pr_next_angle_ack; optionally checks the cycles spent waiting
  task automatic wait_ack(input string name, input int exp_n, input logic chk_n, output logic hs_req);
    int k;
    k = 0;
    @(negedge clk);
    while (!pr_next_angle_ack && k < 400) begin
      tick();
      @(negedge clk);
      k++;
    end
    hs_req = hs_next_angle;
    if (!pr_next_angle_ack) chk({name, "_timeout"}, 0, 1);
    else if (chk_n) chk(name, k, exp_n);
    tick();
  endtask

  // monitor: angle tags after each granted rotation, read data one cycle after each read
  always @(posedge clk) rd_pend <= rd_req;
  always @(negedge clk) begin
    if (ang_pend) begin
      if (ang_q.size() == 0) chk("unexpected_pr_ack", 1, 0);
      else begin
        e_ang = ang_q.pop_front();
        chk("pr0_angle", int'(pr0_angle), e_ang.a0);
        chk("pr1_angle", int'(pr1_angle), e_ang.a1);
        chk("pr0_angle_valid", int'(pr0_angle_valid), int'(e_ang.v0));
        chk("pr1_angle_valid", int'(pr1_angle_valid), int'(e_ang.v1));
      end
    end
    ang_pend = reset_n && pr_next_angle_ack;
    if (rd_pend) begin
      if (rd_q.size() == 0) chk("unexpected_read", 1, 0);
      else begin
        e_rd = rd_q.pop_front();
        if (e_rd.c0) chk("pr0_val", int'(pr0_val), e_rd.d0);
        if (e_rd.c1) chk("pr1_val", int'(pr1_val), e_rd.d1);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    @(negedge clk);
    chk("rst_hs_s_val", int'(hs_s_val), 0);
    chk("rst_hs_next_angle", int'(hs_next_angle), 0);
    chk("rst_pr_ack", int'(pr_next_angle_ack), 0);
    chk("rst_pr0_valid", int'(pr0_angle_valid), 0);
    chk("rst_pr1_valid", int'(pr1_angle_valid), 0);
    chk("rst_pr0_angle", int'(pr0_angle), 0);
    chk("rst_pr1_angle", int'(pr1_angle), 0);
    tick();
    reset_n = 1'b1;
    tick();
    // READY: host ack starts angle 10 into buffer 2
    hs_angle = 10;
    hs_has_next_angle = 1'b1;
    base = 0;
    hs_next_angle_ack = 1'b1;
    @(negedge clk);
    chk("ready_no_pr_ack", int'(pr_next_angle_ack), 0);
    chk("ready_no_hs_req", int'(hs_next_angle), 0);
    tick();
    hs_next_angle_ack = 1'b0;
    for (int i = 0; i < S_COUNT; i++) begin
      @(negedge clk);
      chk("fill_addr", int'(hs_s_val), i);
      tick();
    end
    @(negedge clk);
    chk("fill_done_k257", int'(hs_next_angle), 0);
    tick();
    @(negedge clk);
    chk("fill_done_k258", int'(hs_next_angle), 0);
    tick();
    @(negedge clk);
    chk("fill_done_k259", int'(hs_next_angle), 1);
    chk("fill_pr0_valid", int'(pr0_angle_valid), 0);
    tick();
    // FILL: ack angle 20, processing granted angle 10
    hs_angle = 20;
    base = 2000;
    hs_next_angle_ack = 1'b1;
    ang_q.push_back('{10, 0, 1'b1, 1'b0});
    @(negedge clk);
    chk("fill_pr_ack", int'(pr_next_angle_ack), 1);
    tick();
    hs_next_angle_ack = 1'b0;
    pr_next_angle = 1'b1;
    // FILL_WORK_1: pr0 is buffer 2 holding address values
    rd(37, 37, 1'b1, 0, 0, 1'b0);
    rd(255, 255, 1'b1, 0, 0, 1'b0);
    rd(0, 0, 1'b1, 0, 0, 1'b0);
    n = 0;
    cnt = 0;
    @(negedge clk);
    while (!hs_next_angle && n < 400) begin
      if (pr_next_angle_ack) cnt++;
      tick();
      @(negedge clk);
      n++;
    end
    chk("fw1_fill_wait", n, 255);
    chk("fw1_no_early_ack", cnt, 0);
    chk("fw1_wait_host", int'(pr_next_angle_ack), 0);
    tick();
    hs_angle = 30;
    base = 3000;
    hs_next_angle_ack = 1'b1;
    ang_q.push_back('{20, 10, 1'b1, 1'b1});
    @(negedge clk);
    chk("fw1_pr_ack", int'(pr_next_angle_ack), 1);
    tick();
    hs_next_angle_ack = 1'b0;
    pr_next_angle = 1'b0;
    // FILL_WORK_2 after wrap to rotate_sel 0: pr0 = buffer 1, pr1 = buffer 2
    rd(37, 2037, 1'b1, 255, 255, 1'b1);
    rd(0, 2000, 1'b1, 37, 37, 1'b1);
    rd(255, 2255, 1'b1, 0, 0, 1'b1);
    hs_has_next_angle = 1'b0;
    pr_next_angle = 1'b1;
    ang_q.push_back('{30, 20, 1'b1, 1'b1});
    wait_ack("fw2_fill_wait", 255, 1'b1, hs_at);
    chk("fw2_no_hs_req", int'(hs_at), 0);
    pr_next_angle = 1'b0;
    // WORK_1: pr0 = buffer 0 (angle 30), pr1 = buffer 1 (angle 20)
    rd(37, 3037, 1'b1, 37, 2037, 1'b1);
    rd(255, 3255, 1'b1, 0, 2000, 1'b1);
    pr_next_angle = 1'b1;
    ang_q.push_back('{30, 30, 1'b0, 1'b1});
    wait_ack("work1", 0, 1'b0, hs_at);
    pr_next_angle = 1'b0;
    // WORK_2: pr1 = buffer 0; only pr_done leaves
    rd(0, 0, 1'b0, 100, 3100, 1'b1);
    pr_next_angle = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (pr_next_angle_ack || hs_next_angle) cnt++;
      tick();
    end
    chk("work2_no_ack", cnt, 0);
    pr_done = 1'b1;
    tick();
    pr_done = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (pr_next_angle_ack || hs_next_angle) cnt++;
      tick();
    end
    chk("ready_idle", cnt, 0);
    pr_next_angle = 1'b0;
    repeat (300) tick();
    // READY again: host ack rotates without a processing grant
    hs_angle = 40;
    hs_has_next_angle = 1'b1;
    hs_next_angle_ack = 1'b1;
    tick();
    hs_next_angle_ack = 1'b0;
    @(negedge clk);
    chk("ready2_pr0_angle", int'(pr0_angle), 30);
    chk("ready2_pr0_valid", int'(pr0_angle_valid), 0);
    chk("ready2_pr1_angle", int'(pr1_angle), 30);
    chk("ready2_pr1_valid", int'(pr1_angle_valid), 0);
    chk("ready2_addr0", int'(hs_s_val), 0);
    tick();
    @(negedge clk);
    chk("ready2_addr1", int'(hs_s_val), 1);
    tick();
    tick();
    chk("sb_angle_drain", ang_q.size(), 0);
    chk("sb_read_drain", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
